pipe_sub32: RTL and testbench

PIPE_SUB32 -- requirements
Module: pipe_sub32

---
 rtl/pipe_sub_pkg.sv | 27 ++
 rtl/cls4.sv | 36 +++
 rtl/pipe_sub32.sv | 135 +++++++++++++
 tb/tb_pipe_sub32.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_sub_pkg.sv
// Shared sizes and the stage-register payload for the pipelined 32-bit subtractor.
// Contents:
//   WIDTH  - operand / result width
//   SLICE  - result bits resolved per pipeline stage
//   STAGES - number of pipeline stages
//   CLS_W  - width of one carry-lookahead subtract slice
//   stage_t - per-stage register: partial difference, borrow, operands, sign bits, valid
package pipe_sub_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SLICE  = 8;
  localparam int unsigned STAGES = 4;
  localparam int unsigned CLS_W  = 4;

  // d accumulates resolved result bits from the LSB up; a/b carry the operands
  // forward so later stages can read their still-unprocessed slices.
  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bw;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_msb;
    logic             b_msb;
    logic             valid;
  } stage_t;

endpackage

// File: rtl/cls4.sv
// 4-bit carry-lookahead subtract slice: d = a - b - bw_in, with borrow-out.
// Ports:
//   a, b   [3:0] in  - minuend / subtrahend slice
//   bw_in        in  - borrow into bit 0
//   d      [3:0] out - difference slice (combinational)
//   bw_out       out - borrow out of bit 3 (combinational)
module cls4
  import pipe_sub_pkg::*;
(
  input  logic [CLS_W-1:0] a,
  input  logic [CLS_W-1:0] b,
  input  logic             bw_in,
  output logic [CLS_W-1:0] d,
  output logic             bw_out
);

  // Bit borrows when a=0,b=1 (generate) or passes an incoming borrow when a==b (propagate).
  logic [CLS_W-1:0] w_g;
  logic [CLS_W-1:0] w_p;
  logic [CLS_W:0]   w_c;

  assign w_g = ~a & b;
  assign w_p = ~(a ^ b);

  // Flattened lookahead: every borrow is a direct function of g, p and bw_in.
  assign w_c[0] = bw_in;
  assign w_c[1] = w_g[0] | (w_p[0] & bw_in);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & bw_in);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & bw_in);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0])
                | (&w_p[3:0] & bw_in);

  assign d      = a ^ b ^ w_c[CLS_W-1:0];
  assign bw_out = w_c[CLS_W];

endmodule

// File: rtl/pipe_sub32.sv
// Four-stage pipelined 32-bit subtractor with valid/ready handshake.
// Each stage resolves 8 result bits using two cls4 slices, fed by the borrow
// registered in the previous stage. Whole pipe stalls when the output is held.
// Ports:
//   clk, rst          in  - clock, synchronous active-high reset
//   in_valid          in  - operand set present on a, b, b_in
//   in_ready          out - accepting this cycle (combinational)
//   a, b       [31:0] in  - minuend, subtrahend
//   b_in              in  - borrow-in
//   out_valid         out - result present
//   out_ready         in  - consumer accepts result
//   d          [31:0] out - a - b - b_in mod 2^32
//   b_out             out - borrow-out (a < b + b_in unsigned)
//   zero, neg, ovf    out - d==0, d[31], signed overflow
module pipe_sub32
  import pipe_sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  stage_t           r_stg [STAGES];
  stage_t           w_src [STAGES];
  stage_t           w_nxt [STAGES];
  logic [SLICE-1:0] w_diff [STAGES];
  logic [STAGES-1:0] w_bw_mid;
  logic [STAGES-1:0] w_bw_out;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;
  logic             w_advance;
  logic [WIDTH-1:0] w_d_fin;
  logic             w_zero;
  logic             w_neg;
  logic             w_ovf;
  logic             w_unused;

  // Single global enable: the pipe only stops when a finished result is refused.
  assign w_advance = !(r_stg[STAGES-1].valid && !out_ready);
  assign in_ready  = w_advance && !rst;

  // Stage inputs: stage 0 takes the port operands, later stages their predecessor.
  always_comb begin
    w_src[0] = '{d:     '0,
                 bw:    b_in,
                 a:     a,
                 b:     b,
                 a_msb: a[WIDTH-1],
                 b_msb: b[WIDTH-1],
                 valid: in_valid};
    for (int unsigned s = 1; s < STAGES; s++) begin
      w_src[s] = r_stg[s-1];
    end
  end

  // Two chained 4-bit lookahead slices per stage.
  for (genvar gs = 0; gs < STAGES; gs++) begin : g_stage
    localparam int unsigned LSB = gs * SLICE;

    cls4 u_lo (
      .a      (w_src[gs].a[LSB +: CLS_W]),
      .b      (w_src[gs].b[LSB +: CLS_W]),
      .bw_in  (w_src[gs].bw),
      .d      (w_diff[gs][CLS_W-1:0]),
      .bw_out (w_bw_mid[gs])
    );

    cls4 u_hi (
      .a      (w_src[gs].a[LSB+CLS_W +: CLS_W]),
      .b      (w_src[gs].b[LSB+CLS_W +: CLS_W]),
      .bw_in  (w_bw_mid[gs]),
      .d      (w_diff[gs][SLICE-1:CLS_W]),
      .bw_out (w_bw_out[gs])
    );
  end

  // Merge each stage's new slice into the partial difference and swap in its borrow.
  always_comb begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      w_nxt[s]    = w_src[s];
      w_nxt[s].d  = w_src[s].d | (WIDTH'(w_diff[s]) << (s * SLICE));
      w_nxt[s].bw = w_bw_out[s];
    end
  end

  // Flags come from the complete difference as it enters the last stage.
  assign w_d_fin = w_nxt[STAGES-1].d;
  assign w_zero  = (w_d_fin == '0);
  assign w_neg   = w_d_fin[WIDTH-1];
  assign w_ovf   = (w_nxt[STAGES-1].a_msb ^ w_nxt[STAGES-1].b_msb)
                 & (w_d_fin[WIDTH-1] ^ w_nxt[STAGES-1].a_msb);

  // Pipeline registers: reset clears everything, otherwise load-or-hold as one unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        r_stg[s] <= '0;
      end
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_advance) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        r_stg[s] <= w_nxt[s];
      end
      r_zero <= w_zero;
      r_neg  <= w_neg;
      r_ovf  <= w_ovf;
    end
  end

  assign out_valid = r_stg[STAGES-1].valid;
  assign d         = r_stg[STAGES-1].d;
  assign b_out     = r_stg[STAGES-1].bw;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

  // Operand copies in the last stage have no consumer once the result is complete.
  assign w_unused = ^{r_stg[STAGES-1].a, r_stg[STAGES-1].b,
                      r_stg[STAGES-1].a_msb, r_stg[STAGES-1].b_msb};

endmodule

// File: tb/tb_pipe_sub32.sv
// Directed self-checking bench for pipe_sub32: reset state, arithmetic corner
// vectors, 4-cycle latency, output stall with back-pressure, and reset flush.
module tb_pipe_sub32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        b_out;
  logic        zero;
  logic        neg;
  logic        ovf;

  int n_cmp;
  int n_err;

  pipe_sub32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .b_out     (b_out),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one operand set, confirm nothing appears early, then check the result 4 cycles on.
  task automatic run_one(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vbi, input logic [31:0] ed, input logic eb,
                         input logic ez, input logic en, input logic eo);
    a = va; b = vb; b_in = vbi; in_valid = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
      next_cycle();
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".d"},         d,              ed);
    chk({tag, ".b_out"},     32'(b_out),     32'(eb));
    chk({tag, ".zero"},      32'(zero),      32'(ez));
    chk({tag, ".neg"},       32'(neg),       32'(en));
    chk({tag, ".ovf"},       32'(ovf),       32'(eo));
    next_cycle();
    chk({tag, ".drained"},   32'(out_valid), 32'd0);
  endtask

  logic [31:0] sa  [4];
  logic [31:0] sb  [4];
  logic        sbi [4];
  logic [31:0] sd  [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; b_in = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.d",         d,              32'd0);
    chk("rst.b_out",     32'(b_out),     32'd0);
    chk("rst.zero",      32'(zero),      32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    next_cycle();
    chk("post_rst.in_ready",  32'(in_ready),  32'd1);
    chk("post_rst.out_valid", 32'(out_valid), 32'd0);

    // Arithmetic vectors
    run_one("v5m3",   32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("v0m1",   32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("vminm1", 32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_one("veq",    32'h0000_1234,  32'h0000_1234,  1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_one("veq_bi", 32'h0000_1234,  32'h0000_1234,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("vchain", 32'h0100_0000,  32'd1,          1'b0, 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("vmaxm1", 32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Back-to-back inputs, then hold the output for 3 cycles
    sa[0] = 32'd10;         sb[0] = 32'd3;         sbi[0] = 1'b0; sd[0] = 32'h0000_0007;
    sa[1] = 32'h0000_0100;  sb[1] = 32'd1;         sbi[1] = 1'b0; sd[1] = 32'h0000_00FF;
    sa[2] = 32'd0;          sb[2] = 32'd0;         sbi[2] = 1'b1; sd[2] = 32'hFFFF_FFFF;
    sa[3] = 32'hFFFF_FFFF;  sb[3] = 32'hFFFF_FFFF; sbi[3] = 1'b0; sd[3] = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      a = sa[i]; b = sb[i]; b_in = sbi[i]; in_valid = 1'b1;
      #1;
      chk("b2b.in_ready", 32'(in_ready), 32'd1);
      next_cycle();
    end
    chk("b2b.first_valid", 32'(out_valid), 32'd1);
    chk("b2b.first_d",     d,              sd[0]);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("stall.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("stall.out_valid", 32'(out_valid), 32'd1);
      chk("stall.d",         d,              sd[0]);
      chk("stall.hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      next_cycle();
      chk("drain.out_valid", 32'(out_valid), 32'd1);
      chk("drain.d",         d,              sd[i]);
    end
    next_cycle();
    chk("drain.empty", 32'(out_valid), 32'd0);

    // Reset with three items in flight
    for (int i = 0; i < 3; i++) begin
      a = 32'(100 * (i + 1)); b = 32'(i + 1); b_in = 1'b0; in_valid = 1'b1;
      next_cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk("flush.d", d, 32'd0);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("flush.out_valid", 32'(out_valid), 32'd0);
    end
    run_one("after_flush", 32'h1234_5678, 32'h0234_5678, 1'b0, 32'h1000_0000,
            1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
